// File: rtl/window_stream_ctrl.sv
// Window controller: tracks a BUF_W x BUF_H window in the pixel stream and drives buffer shift strobes.
// Optional sticky drop detection is enabled by defining WINDOW_STREAM_CTRL_OVERRUN_EN.
module window_stream_ctrl #(
  parameter int X_BW     = 10,
  parameter int Y_BW     = 9,
  parameter int BUF_W    = 28,
  parameter int BUF_H    = 28,
  parameter int PIXEL_BW = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [X_BW-1:0]     buffer_x_pos,
  input  logic [Y_BW-1:0]     buffer_y_pos,
  input  logic                pos_load,
  input  logic                pixel_valid,
  input  logic [X_BW-1:0]     screen_x,
  input  logic [Y_BW-1:0]     screen_y,
  input  logic [PIXEL_BW-1:0] pixel_in,
  output logic [PIXEL_BW-1:0] pixel_out,
  output logic                shift_left,
  output logic                shift_up,
  output logic                buffer_rdy,
  input  logic                buffer_ack,
  output logic                overrun
);

  localparam int CW = $clog2(BUF_W);
  localparam int RW = $clog2(BUF_H);
  localparam logic [X_BW:0] WIN_W    = (X_BW+1)'(BUF_W);
  localparam logic [Y_BW:0] WIN_H    = (Y_BW+1)'(BUF_H);
  localparam logic [CW-1:0] COL_LAST = CW'(BUF_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(BUF_H - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, READY = 2'd2} state_t;

  state_t              state_r;
  logic [X_BW-1:0]     sx_r, ax_r;
  logic [Y_BW-1:0]     sy_r, ay_r;
  logic [CW-1:0]       col_cnt_r;
  logic [RW-1:0]       row_cnt_r;
  logic                pend_r;
  logic [PIXEL_BW-1:0] pixel_out_r;
  logic                shift_left_r, shift_up_r, buffer_rdy_r;

  logic                frame_start_s, in_win_s, origin_s;
  logic [X_BW-1:0]     cur_x_s;
  logic [Y_BW-1:0]     cur_y_s;

  // Window test; a frame-start pixel outside READY is judged against the freshly loaded shadow position
  always_comb begin
    frame_start_s = pixel_valid && (screen_x == {X_BW{1'b0}}) && (screen_y == {Y_BW{1'b0}});
    if (frame_start_s && (state_r != READY)) begin
      cur_x_s = sx_r;
      cur_y_s = sy_r;
    end else begin
      cur_x_s = ax_r;
      cur_y_s = ay_r;
    end
    in_win_s = pixel_valid
            && ({1'b0, screen_x} >= {1'b0, cur_x_s})
            && ({1'b0, screen_x} <  ({1'b0, cur_x_s} + WIN_W))
            && ({1'b0, screen_y} >= {1'b0, cur_y_s})
            && ({1'b0, screen_y} <  ({1'b0, cur_y_s} + WIN_H));
    origin_s = pixel_valid && (screen_x == cur_x_s) && (screen_y == cur_y_s);
  end

  // Shadow position capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sx_r <= {X_BW{1'b0}};
      sy_r <= {Y_BW{1'b0}};
    end else if (pos_load) begin
      sx_r <= buffer_x_pos;
      sy_r <= buffer_y_pos;
    end
  end

  // Fill sequencer with registered strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      ax_r         <= {X_BW{1'b0}};
      ay_r         <= {Y_BW{1'b0}};
      col_cnt_r    <= {CW{1'b0}};
      row_cnt_r    <= {RW{1'b0}};
      pend_r       <= 1'b0;
      pixel_out_r  <= {PIXEL_BW{1'b0}};
      shift_left_r <= 1'b0;
      shift_up_r   <= 1'b0;
      buffer_rdy_r <= 1'b0;
    end else begin
      shift_left_r <= 1'b0;
      shift_up_r   <= pend_r;
      pend_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (frame_start_s) begin
            ax_r <= sx_r;
            ay_r <= sy_r;
          end
          if (origin_s) begin
            shift_left_r <= 1'b1;
            pixel_out_r  <= pixel_in;
            col_cnt_r    <= CW'(1);
            row_cnt_r    <= {RW{1'b0}};
            state_r      <= FILL;
          end
        end
        FILL: begin
          if (frame_start_s) begin
            // Abort the partial window; any pending row advance is cancelled
            ax_r       <= sx_r;
            ay_r       <= sy_r;
            shift_up_r <= 1'b0;
            row_cnt_r  <= {RW{1'b0}};
            if (origin_s) begin
              shift_left_r <= 1'b1;
              pixel_out_r  <= pixel_in;
              col_cnt_r    <= CW'(1);
            end else begin
              col_cnt_r <= {CW{1'b0}};
              state_r   <= IDLE;
            end
          end else begin
            if (in_win_s) begin
              shift_left_r <= 1'b1;
              pixel_out_r  <= pixel_in;
              if (col_cnt_r == COL_LAST) begin
                col_cnt_r <= {CW{1'b0}};
                pend_r    <= 1'b1;
              end else begin
                col_cnt_r <= col_cnt_r + CW'(1);
              end
            end
            if (shift_up_r) begin
              if (row_cnt_r == ROW_LAST) begin
                row_cnt_r    <= {RW{1'b0}};
                state_r      <= READY;
                buffer_rdy_r <= 1'b1;
              end else begin
                row_cnt_r <= row_cnt_r + RW'(1);
              end
            end
          end
        end
        READY: begin
          if (buffer_ack) begin
            state_r      <= IDLE;
            buffer_rdy_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          buffer_rdy_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef WINDOW_STREAM_CTRL_OVERRUN_EN
  logic overrun_r;

  // Sticky flag for window pixels lost while the consumer still holds the buffer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_r <= 1'b0;
    end else if ((state_r == READY) && in_win_s) begin
      overrun_r <= 1'b1;
    end
  end

  assign overrun = overrun_r;
`else
  assign overrun = 1'b0;
`endif

  assign pixel_out  = pixel_out_r;
  assign shift_left = shift_left_r;
  assign shift_up   = shift_up_r;
  assign buffer_rdy = buffer_rdy_r;

endmodule
